alkso: RTL
==========

// Module: alkso
// PURPOSE
//  DC615 ALK shift-out capture and iteration control. Samples the ALU and Q shift
//  outputs at the end of each microcycle into the ALUSO and LOOPF flags that steer
//  the A shift-in multiplexer on the next cycle. Owns the MUL/DIV iteration counter
//  (state machine) that terminates multi-cycle arithmetic loops.
// PARAMETERS
//  LCNT_W   6   width of iteration counter (max 2^LCNT_W-1 iterations)
// PORTS
//  clk_h            in   1       microcycle clock, rising edge
//  reset_l          in   1       asynchronous, active-low reset
//  ucyc_en_h        in   1       microcycle advance (0 = stall, hold all state); ALKSO_STALL_EN only
//  alu_shl_op_h     in   1       ALU field specifies *.SL
//  alu_shr_op_h     in   1       ALU field specifies *.SR
//  alu_sout_shl_h   in   1       ALU shifter bit leaving on left shift (bit 31)
//  alu_sout_shr_h   in   1       ALU shifter bit leaving on right shift (bit 0)
//  q_sout_shr_h     in   1       Q shifter bit leaving on right shift (Q[0])
//  alpctl_mul_l     in   1       ALPCTL decodes MUL step
//  alpctl_div_l     in   1       ALPCTL decodes DIV step
//  alpctl_divdbl_l  in   1       ALPCTL decodes DIVD step
//  alpctl_rem_l     in   1       ALPCTL decodes REM step
//  loop_ld_h        in   1       load iteration counter
//  loop_cnt_in_h    in   LCNT_W  iteration count to load
//  aluso_h          out  1       registered ALU shift-out flag (ALUSO/ALUF)
//  loopf_h          out  1       registered loop flag (multiplier bit)
//  loop_cnt_h       out  LCNT_W  remaining iterations
//  loop_busy_h      out  1       state RUN or LAST
//  loop_done_h      out  1       one-cycle pulse on final iteration retire
// BEHAVIOUR
//  - Reset (async, reset_l=0): aluso_h=0, loopf_h=0, loop_cnt_h=0, state IDLE,
//    loop_busy_h=0, loop_done_h=0. Deassertion mid-loop restarts in IDLE.
//  - "adv" = ucyc_en_h (forced 1 without macro). adv=0: every register holds,
//    loop_done_h forced 0. All updates below occur only on clk_h edges with adv=1.
//  - arith = any of alpctl_{mul,div,divdbl,rem}_l low.
//  - ALUSO: alu_shl_op_h=1 -> alu_sout_shl_h; else alu_shr_op_h=1 -> alu_sout_shr_h;
//    else hold. Both ops set: SL wins. Latency 1 cycle (visible next microcycle).
//  - LOOPF: loop_ld_h=1 -> 0; else alpctl_mul_l=0 -> q_sout_shr_h; else hold.
//  - Counter/FSM (states IDLE, RUN, LAST):
//    * loop_ld_h=1 in any state: cnt<=loop_cnt_in_h; value 0 treated as 1.
//      Next state RUN if loaded value >1, else LAST. Load beats decrement.
//    * RUN & arith: cnt<=cnt-1; if new cnt==1 -> LAST. RUN & !arith: hold.
//    * LAST & arith: cnt<=0, -> IDLE, loop_done_h=1 for exactly that cycle.
//      LAST & !arith: hold.
//    * IDLE & arith & !loop_ld_h: no count change, no done (no wrap below 0).
//  - loop_busy_h = (state!=IDLE), combinational from state register.
//  - loop_done_h registered; deasserts next adv cycle or on stall.
// CONFIGURATION
//  ALKSO_STALL_EN defined: ucyc_en_h port present, stalls freeze all state.
//  Not defined: port absent, adv tied 1, logic otherwise identical.
// TESTING
//  1. reset_l=0 mid-RUN (cnt=5) -> all outputs 0, IDLE immediately, no clock needed.
//  2. load 3, MUL active 3 cycles -> cnt 3,2,1(LAST),0; loop_done_h=1 on 3rd edge only.
//  3. alu_shl_op_h=alu_shr_op_h=1, sout_shl=1, sout_shr=0 -> aluso_h=1 next cycle.
//  4. load 0 -> LAST, cnt=1; one DIV cycle -> IDLE, done pulse; extra DIV -> cnt stays 0.
//  5. RUN cnt=4, load 7 same cycle as MUL -> cnt=7, loopf_h=0.
//  6. (ALKSO_STALL_EN) ucyc_en_h=0 for 2 cycles in LAST -> cnt, flags, state held, done=0.

Source files
------------

// File: rtl/alkso.sv
// alkso -- ALK shift-out capture and MUL/DIV iteration control.
//
// Captures the ALU and Q shifter bits that leave on a shift at the end of each
// microcycle. These become the ALUSO and LOOPF flags, which steer the A shift-in
// multiplexer on the next cycle. Also owns the iteration counter that ends
// multi-cycle MUL/DIV/DIVD/REM loops.
//
// Optional feature macro: ALKSO_STALL_EN
//   defined   : ucyc_en_h port present; ucyc_en_h=0 freezes all state.
//   undefined : port absent; every clk_h edge advances the microcycle.
//
// Ports
//   clk_h            in   microcycle clock, rising edge
//   reset_l          in   asynchronous active-low reset
//   ucyc_en_h        in   microcycle advance (ALKSO_STALL_EN builds only)
//   alu_shl_op_h     in   ALU op is a left shift
//   alu_shr_op_h     in   ALU op is a right shift
//   alu_sout_shl_h   in   ALU bit leaving on left shift (bit 31)
//   alu_sout_shr_h   in   ALU bit leaving on right shift (bit 0)
//   q_sout_shr_h     in   Q bit leaving on right shift (Q[0])
//   alpctl_*_l       in   active-low MUL/DIV/DIVD/REM step decodes
//   loop_ld_h        in   load the iteration counter
//   loop_cnt_in_h    in   iteration count to load (0 is treated as 1)
//   aluso_h          out  registered ALU shift-out flag
//   loopf_h          out  registered loop flag (multiplier bit)
//   loop_cnt_h       out  remaining iterations
//   loop_busy_h      out  counter is in RUN or LAST
//   loop_done_h      out  one-cycle pulse when the final iteration retires
module alkso #(
  parameter int LCNT_W = 6
) (
  input  logic              clk_h,
  input  logic              reset_l,
`ifdef ALKSO_STALL_EN
  input  logic              ucyc_en_h,
`endif
  input  logic              alu_shl_op_h,
  input  logic              alu_shr_op_h,
  input  logic              alu_sout_shl_h,
  input  logic              alu_sout_shr_h,
  input  logic              q_sout_shr_h,
  input  logic              alpctl_mul_l,
  input  logic              alpctl_div_l,
  input  logic              alpctl_divdbl_l,
  input  logic              alpctl_rem_l,
  input  logic              loop_ld_h,
  input  logic [LCNT_W-1:0] loop_cnt_in_h,
  output logic              aluso_h,
  output logic              loopf_h,
  output logic [LCNT_W-1:0] loop_cnt_h,
  output logic              loop_busy_h,
  output logic              loop_done_h
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  state_e            state_q;
  logic [LCNT_W-1:0] cnt_q;
  logic              aluso_q, aluso_d;
  logic              loopf_q, loopf_d;
  logic              done_q;
  logic              adv;
  logic              arith;
  logic [LCNT_W-1:0] ld_val;

`ifdef ALKSO_STALL_EN
  assign adv = ucyc_en_h;
`else
  assign adv = 1'b1;
`endif

  assign arith  = ~(alpctl_mul_l & alpctl_div_l & alpctl_divdbl_l & alpctl_rem_l);
  // A zero load still runs one iteration.
  assign ld_val = (loop_cnt_in_h == '0) ? LCNT_W'(1) : loop_cnt_in_h;

  // Left shift has priority when the ALU field somehow asserts both directions.
  always_comb begin
    aluso_d = aluso_q;
    if (alu_shl_op_h)      aluso_d = alu_sout_shl_h;
    else if (alu_shr_op_h) aluso_d = alu_sout_shr_h;
  end

  always_comb begin
    loopf_d = loopf_q;
    if (loop_ld_h)          loopf_d = 1'b0;
    else if (!alpctl_mul_l) loopf_d = q_sout_shr_h;
  end

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      aluso_q <= 1'b0;
      loopf_q <= 1'b0;
    end else if (adv) begin
      aluso_q <= aluso_d;
      loopf_q <= loopf_d;
    end
  end

  // Iteration counter FSM. The counter value and state always agree:
  // RUN holds cnt>1, LAST holds cnt==1, IDLE holds cnt==0.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (!adv) begin
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (loop_ld_h) begin
        cnt_q   <= ld_val;
        state_q <= (ld_val > LCNT_W'(1)) ? RUN : LAST;
      end else begin
        case (state_q)
          RUN: if (arith) begin
            cnt_q <= cnt_q - LCNT_W'(1);
            if (cnt_q == LCNT_W'(2)) state_q <= LAST;
          end
          LAST: if (arith) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
          default: ;  // IDLE: arithmetic without a load never wraps the count
        endcase
      end
    end
  end

  assign aluso_h     = aluso_q;
  assign loopf_h     = loopf_q;
  assign loop_cnt_h  = cnt_q;
  assign loop_busy_h = (state_q != IDLE);
  assign loop_done_h = done_q;

endmodule
